// File: rtl/bus6502_mmc1_wr_pkg.sv
// ----------------------------------------------------------------------------
// bus6502_mmc1_wr_pkg
//   Shared definitions for the MMC1 write-side block:
//   - MMC1 register index constants, selected by CPU A14..A13
//   - reset value of the control register and the empty shift-register pattern
//   - encodings for the M2 sequencer FSM
//   - a helper that models one serial bit entering the MMC1 shift register
// ----------------------------------------------------------------------------
package bus6502_mmc1_wr_pkg;

  // Register index, decoded from A14..A13 of the fifth serial write
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG  = 2'd3;

  // Power-on control: PRG mode 3 (fix last bank at $C000), one-screen mirroring
  localparam logic [4:0] CTRL_RESET_VAL = 5'h0C;

  // The marker bit starts at the top and walks down one place per write. When it
  // reaches bit 0, the next write is the fifth one and completes the load.
  localparam logic [4:0] SHIFT_EMPTY = 5'b10000;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_WAIT   = 2'd1,
    SEQ_SAMPLE = 2'd2,
    SEQ_HOLD   = 2'd3
  } seq_state_t;

  // The new bit enters at the MSB and the register shifts toward the LSB
  function automatic logic [4:0] shift_in(input logic [4:0] sr, input logic bit_in);
    return {bit_in, sr[4:1]};
  endfunction

endpackage

// File: rtl/bus6502_mmc1_wr_m2_sampler.sv
// ----------------------------------------------------------------------------
// bus6502_mmc1_wr_m2_sampler
//   Brings the asynchronous NES CPU bus into the fclk domain. It synchronises
//   M2, R/W and /ROMSEL, finds the rising edge of M2, waits SAMPLE_DLY clocks
//   for the address and data to settle, and then latches the bus once.
//   Ports:
//     clk, rst              fabric clock, async active-high reset
//     c6502_m2/rw/rom_sel_n raw CPU control lines (asynchronous)
//     c6502_addr/data       raw CPU address (A14..A0) and data
//     sample_valid          1-clk pulse; the smp_* outputs hold this M2 cycle
//     cycle_abort           1-clk pulse when M2 fell before the sample point
//     smp_addr/data/rw/rom_sel_n  bus values latched at the sample point
// ----------------------------------------------------------------------------
module bus6502_mmc1_wr_m2_sampler
  import bus6502_mmc1_wr_pkg::*;
#(
  parameter int SAMPLE_DLY  = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c6502_m2,
  input  logic        c6502_rw,
  input  logic        c6502_rom_sel_n,
  input  logic [14:0] c6502_addr,
  input  logic [7:0]  c6502_data,
  output logic        sample_valid,
  output logic        cycle_abort,
  output logic [14:0] smp_addr,
  output logic [7:0]  smp_data,
  output logic        smp_rw,
  output logic        smp_rom_sel_n
);

  localparam int CNT_W = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SAMPLE_DLY - 1);

  logic [SYNC_STAGES-1:0] m2_sync;
  logic [SYNC_STAGES-1:0] rw_sync;
  logic [SYNC_STAGES-1:0] rsn_sync;
  logic                   m2_s;
  logic                   m2_prev;
  logic                   m2_rise;
  logic [CNT_W-1:0]       cnt;
  logic                   latch_en;
  seq_state_t             state;
  seq_state_t             state_next;

  // The control lines reset to their idle levels: M2 low, read, ROM not selected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m2_sync  <= '0;
      rw_sync  <= '1;
      rsn_sync <= '1;
      m2_prev  <= 1'b0;
    end else begin
      m2_sync  <= {m2_sync[SYNC_STAGES-2:0],  c6502_m2};
      rw_sync  <= {rw_sync[SYNC_STAGES-2:0],  c6502_rw};
      rsn_sync <= {rsn_sync[SYNC_STAGES-2:0], c6502_rom_sel_n};
      m2_prev  <= m2_s;
    end
  end

  assign m2_s    = m2_sync[SYNC_STAGES-1];
  assign m2_rise = m2_s & ~m2_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // If M2 falls while WAIT is counting, the bus is never sampled. An M2 pulse
  // that short cannot be a real CPU cycle.
  always_comb begin
    state_next = state;
    case (state)
      SEQ_IDLE:   if (m2_rise) state_next = SEQ_WAIT;
      SEQ_WAIT: begin
        if (!m2_s)          state_next = SEQ_IDLE;
        else if (cnt == '0) state_next = SEQ_SAMPLE;
      end
      SEQ_SAMPLE: state_next = SEQ_HOLD;
      SEQ_HOLD:   if (!m2_s) state_next = SEQ_IDLE;
      default:    state_next = SEQ_IDLE;
    endcase
  end

  always_comb begin
    sample_valid = (state == SEQ_SAMPLE);
    cycle_abort  = (state == SEQ_WAIT) && !m2_s;
    latch_en     = (state == SEQ_WAIT) && m2_s && (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == SEQ_IDLE) && m2_rise) begin
      cnt <= CNT_LOAD;
    end else if ((state == SEQ_WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Address and data are sampled raw. By the sample point they have been
  // stable for many clocks, so they do not need a synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_addr      <= '0;
      smp_data      <= '0;
      smp_rw        <= 1'b1;
      smp_rom_sel_n <= 1'b1;
    end else if (latch_en) begin
      smp_addr      <= c6502_addr;
      smp_data      <= c6502_data;
      smp_rw        <= rw_sync[SYNC_STAGES-1];
      smp_rom_sel_n <= rsn_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/bus6502_mmc1_wr.sv
// ----------------------------------------------------------------------------
// bus6502_mmc1_wr
//   Captures CPU writes to $8000-$FFFF and runs the MMC1 5-bit serial loader
//   that feeds the control, CHR0, CHR1 and PRG bank registers.
//   Ports:
//     clk, rst          fabric clock (fclk), async active-high reset
//     c6502_*           raw CPU bus: M2, R/W, /ROMSEL, A14..A0, D7..D0
//     init_sdram_data   writes are ignored until the SDRAM image is loaded
//     reg_control       {chr_mode, prg_mode[1:0], mirror[1:0]}
//     reg_chr0/reg_chr1 CHR bank registers
//     reg_prg           {wram_dis, bank[3:0]}
//     mirroring         reg_control[1:0]
//     wr_strobe         1-clk pulse each time a register is loaded
// ----------------------------------------------------------------------------
module bus6502_mmc1_wr
  import bus6502_mmc1_wr_pkg::*;
#(
  parameter int SAMPLE_DLY  = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c6502_m2,
  input  logic        c6502_rw,
  input  logic        c6502_rom_sel_n,
  input  logic [14:0] c6502_addr,
  input  logic [7:0]  c6502_data,
  input  logic        init_sdram_data,
  output logic [4:0]  reg_control,
  output logic [4:0]  reg_chr0,
  output logic [4:0]  reg_chr1,
  output logic [4:0]  reg_prg,
  output logic [1:0]  mirroring,
  output logic        wr_strobe
);

  logic        sample_valid;
  logic        cycle_abort;
  logic [14:0] smp_addr;
  logic [7:0]  smp_data;
  logic        smp_rw;
  logic        smp_rom_sel_n;
  logic [4:0]  shift;
  logic [4:0]  load_val;
  logic        last_wr;
  logic        qual_wr;
  logic        unused_bits;

  bus6502_mmc1_wr_m2_sampler #(
    .SAMPLE_DLY  (SAMPLE_DLY),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk             (clk),
    .rst             (rst),
    .c6502_m2        (c6502_m2),
    .c6502_rw        (c6502_rw),
    .c6502_rom_sel_n (c6502_rom_sel_n),
    .c6502_addr      (c6502_addr),
    .c6502_data      (c6502_data),
    .sample_valid    (sample_valid),
    .cycle_abort     (cycle_abort),
    .smp_addr        (smp_addr),
    .smp_data        (smp_data),
    .smp_rw          (smp_rw),
    .smp_rom_sel_n   (smp_rom_sel_n)
  );

  // MMC1 decodes only A14..A13 and data bits D7 and D0. The other bus bits
  // are don't-care here.
  assign unused_bits = ^{smp_addr[12:0], smp_data[6:1]};

  assign qual_wr  = !smp_rw && !smp_rom_sel_n && init_sdram_data;
  assign load_val = shift_in(shift, smp_data[0]);
  assign mirroring = reg_control[1:0];

  // A read-modify-write instruction writes twice in consecutive cycles, and
  // MMC1 uses only the first of the two. last_wr remembers whether the
  // previous completed cycle was a qualified write. An aborted cycle clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_control <= CTRL_RESET_VAL;
      reg_chr0    <= '0;
      reg_chr1    <= '0;
      reg_prg     <= '0;
      shift       <= SHIFT_EMPTY;
      last_wr     <= 1'b0;
      wr_strobe   <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (cycle_abort) begin
        last_wr <= 1'b0;
      end else if (sample_valid) begin
        last_wr <= qual_wr;
        if (qual_wr && !last_wr) begin
          if (smp_data[7]) begin
            shift       <= SHIFT_EMPTY;
            reg_control <= reg_control | CTRL_RESET_VAL;
          end else if (shift[0]) begin
            shift     <= SHIFT_EMPTY;
            wr_strobe <= 1'b1;
            case (smp_addr[14:13])
              REG_CTRL: reg_control <= load_val;
              REG_CHR0: reg_chr0    <= load_val;
              REG_CHR1: reg_chr1    <= load_val;
              REG_PRG:  reg_prg     <= load_val;
              default:  reg_prg     <= load_val;
            endcase
          end else begin
            shift <= load_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bus6502_mmc1_wr.sv
// ----------------------------------------------------------------------------
// tb_bus6502_mmc1_wr
//   Drives complete CPU M2 cycles into bus6502_mmc1_wr and compares the bank
//   registers, the mirroring output and the number of wr_strobe pulses after
//   each transaction.
// ----------------------------------------------------------------------------
module tb_bus6502_mmc1_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic        c6502_m2;
  logic        c6502_rw;
  logic        c6502_rom_sel_n;
  logic [14:0] c6502_addr;
  logic [7:0]  c6502_data;
  logic        init_sdram_data;
  logic [4:0]  reg_control;
  logic [4:0]  reg_chr0;
  logic [4:0]  reg_chr1;
  logic [4:0]  reg_prg;
  logic [1:0]  mirroring;
  logic        wr_strobe;

  typedef struct {
    logic        rw;
    logic        rsn;
    logic [14:0] addr;
    logic [7:0]  data;
    logic        init;
    int          high_clks;
    logic [4:0]  ctrl;
    logic [4:0]  chr0;
    logic [4:0]  chr1;
    logic [4:0]  prg;
    int          strobes;
  } vec_t;

  typedef struct {
    logic [4:0] ctrl;
    logic [4:0] chr0;
    logic [4:0] chr1;
    logic [4:0] prg;
    int         strobes;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   strobe_total = 0;
  int   strobe_base = 0;

  bus6502_mmc1_wr #(
    .SAMPLE_DLY  (20),
    .SYNC_STAGES (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .c6502_m2        (c6502_m2),
    .c6502_rw        (c6502_rw),
    .c6502_rom_sel_n (c6502_rom_sel_n),
    .c6502_addr      (c6502_addr),
    .c6502_data      (c6502_data),
    .init_sdram_data (init_sdram_data),
    .reg_control     (reg_control),
    .reg_chr0        (reg_chr0),
    .reg_chr1        (reg_chr1),
    .reg_prg         (reg_prg),
    .mirroring       (mirroring),
    .wr_strobe       (wr_strobe)
  );

  always #5 clk = ~clk;

  // Sampling on the falling edge counts each 1-clk strobe exactly once. A
  // strobe that stays high longer is counted more than once.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_total++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic rw, input logic rsn, input logic [14:0] addr,
                              input logic [7:0] data, input logic init, input int high_clks,
                              input logic [4:0] ctrl, input logic [4:0] chr0,
                              input logic [4:0] chr1, input logic [4:0] prg,
                              input int strobes);
    vec_t v;
    v.rw = rw; v.rsn = rsn; v.addr = addr; v.data = data; v.init = init;
    v.high_clks = high_clks; v.ctrl = ctrl; v.chr0 = chr0; v.chr1 = chr1;
    v.prg = prg; v.strobes = strobes;
    return v;
  endfunction

  task automatic pushExpect(input logic [4:0] ctrl, input logic [4:0] chr0,
                            input logic [4:0] chr1, input logic [4:0] prg,
                            input int strobes);
    exp_t e;
    e.ctrl = ctrl; e.chr0 = chr0; e.chr1 = chr1; e.prg = prg; e.strobes = strobes;
    sb.push_back(e);
    strobe_base = strobe_total;
  endtask

  // One CPU bus cycle. M2 is high for high_clks fclk cycles, then low for 8.
  task automatic m2Cycle(input logic rw, input logic rsn, input logic [14:0] addr,
                         input logic [7:0] data, input int high_clks);
    @(negedge clk);
    c6502_rw = rw; c6502_rom_sel_n = rsn; c6502_addr = addr; c6502_data = data;
    c6502_m2 = 1'b1;
    repeat (high_clks) @(negedge clk);
    c6502_m2 = 1'b0; c6502_rom_sel_n = 1'b1; c6502_rw = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Each vector is followed by a read from outside ROM space, like a normal
  // instruction fetch. That read clears the back-to-back write filter.
  task automatic applyStimulus(input vec_t v);
    init_sdram_data = v.init;
    pushExpect(v.ctrl, v.chr0, v.chr1, v.prg, v.strobes);
    m2Cycle(v.rw, v.rsn, v.addr, v.data, v.high_clks);
    m2Cycle(1'b1, 1'b1, 15'h0000, 8'h80, 40);
  endtask

  task automatic cmp5(input string name, input string field, input logic [4:0] act,
                      input logic [4:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s %s: got %h required %h", name, field, act, req);
    end
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    int   seen;
    logic [4:0] mir_req;
    logic [4:0] mir_act;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s scoreboard: got empty queue required one entry", name);
    end else begin
      e = sb.pop_front();
      seen = strobe_total - strobe_base;
      mir_req = {3'b000, e.ctrl[1:0]};
      mir_act = {3'b000, mirroring};
      cmp5(name, "reg_control", reg_control, e.ctrl);
      cmp5(name, "reg_chr0", reg_chr0, e.chr0);
      cmp5(name, "reg_chr1", reg_chr1, e.chr1);
      cmp5(name, "reg_prg", reg_prg, e.prg);
      cmp5(name, "mirroring", mir_act, mir_req);
      total++;
      if (seen != e.strobes) begin
        bad++;
        $display("[TB] FAIL %s wr_strobe count: got %0d required %0d", name, seen, e.strobes);
      end
    end
  endtask

  initial begin
    // Five serial writes to $E000 load PRG with 5'b01101
    vecs.push_back(mk(0, 0, 15'h6000, 8'h01, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h00, 0));
    vecs.push_back(mk(0, 0, 15'h6000, 8'h00, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h00, 0));
    vecs.push_back(mk(0, 0, 15'h6000, 8'h01, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h00, 0));
    vecs.push_back(mk(0, 0, 15'h6000, 8'h01, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h00, 0));
    vecs.push_back(mk(0, 0, 15'h6000, 8'h00, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h0D, 1));
    // Partial load to $A000, reset with D7, then a full load of 1s into CHR0
    vecs.push_back(mk(0, 0, 15'h2000, 8'h01, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h2000, 8'h00, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h2000, 8'h01, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h2000, 8'h80, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h2000, 8'h01, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h2000, 8'h01, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h2000, 8'h01, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h2000, 8'h01, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h2000, 8'h01, 1, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 1));
    // Writes to $C000 while the SDRAM image is not ready are dropped
    vecs.push_back(mk(0, 0, 15'h4000, 8'h01, 0, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h4000, 8'h01, 0, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h4000, 8'h01, 0, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h4000, 8'h01, 0, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h4000, 8'h01, 0, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    // Short M2 pulses and ROM reads mixed into a control load; effective bits 1,1,0,0,1
    vecs.push_back(mk(0, 0, 15'h0000, 8'h01, 1, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h0000, 8'h00, 1, 10, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(1, 0, 15'h0000, 8'h80, 1, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h0000, 8'h01, 1, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(1, 0, 15'h0000, 8'h80, 1, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h0000, 8'h01, 1, 10, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h0000, 8'h00, 1, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h0000, 8'h00, 1, 40, 5'h0C, 5'h1F, 5'h00, 5'h0D, 0));
    vecs.push_back(mk(0, 0, 15'h0000, 8'h01, 1, 40, 5'h13, 5'h1F, 5'h00, 5'h0D, 1));

    rst = 1'b1; c6502_m2 = 1'b0; c6502_rw = 1'b1; c6502_rom_sel_n = 1'b1;
    c6502_addr = '0; c6502_data = '0; init_sdram_data = 1'b1;
    pushExpect(5'h0C, 5'h00, 5'h00, 5'h00, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // An RMW double write to $8000: the second write is filtered, so the
    // fourth following write, not the third, completes the load.
    init_sdram_data = 1'b1;
    pushExpect(5'h13, 5'h1F, 5'h00, 5'h0D, 0);
    m2Cycle(1'b0, 1'b0, 15'h0000, 8'h01, 40);
    m2Cycle(1'b0, 1'b0, 15'h0000, 8'h01, 40);
    m2Cycle(1'b1, 1'b1, 15'h0000, 8'h80, 40);
    checkOutput("rmw_pair");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(0, 0, 15'h0000, 8'h00, 1, 40, 5'h13, 5'h1F, 5'h00, 5'h0D, 0));
      checkOutput($sformatf("rmw_follow%0d", i));
    end
    applyStimulus(mk(0, 0, 15'h0000, 8'h00, 1, 40, 5'h01, 5'h1F, 5'h00, 5'h0D, 1));
    checkOutput("rmw_load");

    // Reset after a partial load: the partial shift contents must be lost
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(0, 0, 15'h0000, 8'h01, 1, 40, 5'h01, 5'h1F, 5'h00, 5'h0D, 0));
      checkOutput($sformatf("pre_rst%0d", i));
    end
    pushExpect(5'h0C, 5'h00, 5'h00, 5'h00, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_rst");
    applyStimulus(mk(0, 0, 15'h0000, 8'h00, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h00, 0));
    checkOutput("post_rst0");
    applyStimulus(mk(0, 0, 15'h0000, 8'h01, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h00, 0));
    checkOutput("post_rst1");
    applyStimulus(mk(0, 0, 15'h0000, 8'h00, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h00, 0));
    checkOutput("post_rst2");
    applyStimulus(mk(0, 0, 15'h0000, 8'h00, 1, 40, 5'h0C, 5'h00, 5'h00, 5'h00, 0));
    checkOutput("post_rst3");
    applyStimulus(mk(0, 0, 15'h0000, 8'h00, 1, 40, 5'h02, 5'h00, 5'h00, 5'h00, 1));
    checkOutput("post_rst4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
